// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Load-use hazard and stall controller for a classic five-stage pipeline.
//   Detects a dependency between the instruction in ID and a load in EX, and
//   holds PC and IF/ID while feeding LOAD_LAT bubbles into ID/EX. A resolved
//   branch flushes IF/ID and cancels any pending stall. A memory stall
//   (mem_busy) freezes everything, including this controller's own state.
//
// Handshake semantics: branch_taken is a level that upstream holds until it
//   is accepted. It is accepted on any edge where mem_busy is low. mem_busy
//   is a level; while high, no control output asserts and no state advances.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_id_rs, if_id_rt          source specifiers of the instruction in ID
//   if_id_use_rs, if_id_use_rt  ID instruction really reads rs / rt
//   id_ex_rt                    destination of the instruction in EX
//   id_ex_mem_read              EX instruction is a load
//   id_ex_valid                 EX slot holds a real instruction
//   branch_taken                redirect resolved this cycle
//   mem_busy                    data memory not ready; whole pipe frozen
//   perf_clr                    synchronous clear of stall_count
//   pc_write, if_id_write       PC and IF/ID load enables
//   id_ex_bubble                insert a NOP into ID/EX
//   if_id_flush                 clear IF/ID to a NOP
//   stall_active                FSM is in LOAD_STALL (state debug view)
//   stall_count                 saturating count of non-frozen bubble cycles
module hazard_stall_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned LOAD_LAT    = 2,
  parameter int unsigned CNT_W       = 16,
  parameter bit          ZERO_EXEMPT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_use_rs,
  input  logic             if_id_use_rt,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_valid,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } state_e;

  // The hazard cycle itself is the first bubble, so LOAD_STALL only has to
  // cover the remaining LOAD_LAT-1 cycles.
  localparam logic [2:0] REM_INIT = 3'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hazard;
  logic rt_exempt;
  logic rs_match;
  logic rt_match;

  // Control outputs before the reset override.
  logic pc_write_c;
  logic if_id_write_c;
  logic id_ex_bubble_c;
  logic if_id_flush_c;

  assign rt_exempt = ZERO_EXEMPT && (id_ex_rt == '0);
  assign rs_match  = if_id_use_rs && (id_ex_rt == if_id_rs);
  assign rt_match  = if_id_use_rt && (id_ex_rt == if_id_rt);
  assign hazard    = id_ex_valid && id_ex_mem_read && !rt_exempt && (rs_match || rt_match);

  // Next state and outputs, priority: mem_busy, branch_taken, LOAD_STALL, hazard.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    id_ex_bubble_c = 1'b0;
    if_id_flush_c  = 1'b0;

    if (mem_busy) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
    end else if (branch_taken) begin
      id_ex_bubble_c = 1'b1;
      if_id_flush_c  = 1'b1;
      state_d        = IDLE;
      rem_d          = 3'd0;
    end else if (state_q == LOAD_STALL) begin
      // EX contents are ignored here: the stall length was fixed on entry.
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_bubble_c = 1'b1;
      rem_d          = rem_q - 3'd1;
      if (rem_q == 3'd1) begin
        state_d = IDLE;
      end
    end else if (hazard) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_bubble_c = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = LOAD_STALL;
        rem_d   = REM_INIT;
      end
    end
  end

  // While reset is held the pipe must not advance and ID/EX must see NOPs,
  // independent of the clock, so the override is combinational on rst_n.
  always_comb begin
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end else begin
      pc_write     = pc_write_c;
      if_id_write  = if_id_write_c;
      id_ex_bubble = id_ex_bubble_c;
      if_id_flush  = if_id_flush_c;
    end
  end

  // Clear wins over increment; the count saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr) begin
      cnt_d = '0;
    end else if (id_ex_bubble_c && !mem_busy && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_active = (state_q == LOAD_STALL);
  assign stall_count  = cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have parameter LOAD_LAT, default 2, range 1..8: cycles of load-use stall per hazard.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have parameter ZERO_EXEMPT, default 1: if 1, a dependency on register 0 never causes a stall.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port if_id_rs, input, REG_W, source-register specifier of the instruction in ID.
REQ-008 SHALL have port if_id_rt, input, REG_W, second source-register specifier in ID.
REQ-009 SHALL have port if_id_use_rs / if_id_use_rt, input, 1 each, the ID instruction actually reads rs / rt.
REQ-010 SHALL have port id_ex_rt, input, REG_W, destination register of the instruction in EX.
REQ-011 SHALL have port id_ex_mem_read, input, 1, the EX instruction is a load.
REQ-012 SHALL have port id_ex_valid, input, 1, the EX slot holds a real instruction, not a bubble.
REQ-013 SHALL have port branch_taken, input, 1, a redirect resolved this cycle; upstream holds it until it is accepted.
REQ-014 SHALL have port mem_busy, input, 1, data memory is not ready and the whole pipeline freezes.
REQ-015 SHALL have port perf_clr, input, 1, synchronous clear of stall_count.
REQ-016 SHALL have port pc_write, output, 1, PC update enable.
REQ-017 SHALL have port if_id_write, output, 1, IF/ID register load enable.
REQ-018 SHALL have port id_ex_bubble, output, 1, insert a NOP into ID/EX.
REQ-019 SHALL have port if_id_flush, output, 1, clear IF/ID to a NOP.
REQ-020 SHALL have port stall_active, output, 1, the FSM is in LOAD_STALL.
REQ-021 SHALL have port stall_count, output, CNT_W, count of bubble cycles.

Function
REQ-022 SHALL compute hazard = id_ex_valid & id_ex_mem_read & ~(ZERO_EXEMPT & id_ex_rt==0) & ((if_id_use_rs & id_ex_rt==if_id_rs) | (if_id_use_rt & id_ex_rt==if_id_rt)).
REQ-023 SHALL implement a two-state FSM: IDLE and LOAD_STALL, plus a remaining-cycles counter rem, 3 bits wide.
REQ-024 Priority SHALL be, highest first: mem_busy, branch_taken, LOAD_STALL, hazard.
REQ-025 When mem_busy=1: outputs SHALL be pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0; the state, rem and stall_count are held.
REQ-026 When branch_taken=1 and mem_busy=0: outputs SHALL be pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; the next state is IDLE; a pending stall is cancelled.
REQ-027 In IDLE with hazard=1 and no higher-priority event: outputs SHALL be pc_write=0, if_id_write=0, id_ex_bubble=1; if LOAD_LAT>1, the next state is LOAD_STALL with rem=LOAD_LAT-1; otherwise the FSM stays in IDLE.
REQ-028 In LOAD_STALL with no higher-priority event: outputs SHALL be pc_write=0, if_id_write=0, id_ex_bubble=1; EX inputs are ignored; rem decrements; when rem==1, the next state is IDLE.
REQ-029 In IDLE with no event: outputs SHALL be pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
REQ-030 A hazard stall SHALL therefore total exactly LOAD_LAT non-frozen bubble cycles; cycles frozen by mem_busy do not count toward this total.
REQ-031 stall_count SHALL increment on every clock edge where id_ex_bubble=1 and mem_busy=0, and SHALL saturate at 2^CNT_W-1.
REQ-032 When perf_clr=1, stall_count SHALL be 0 on the next edge; perf_clr takes priority over an increment in the same cycle.
REQ-033 stall_active SHALL be registered-state derived: 1 exactly when the state is LOAD_STALL.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state=IDLE, rem=0 and stall_count=0.
REQ-035 While rst_n=0, outputs SHALL be pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, stall_active=0.
REQ-036 Reset asserted mid-stall SHALL abandon the stall; after release, the block is in IDLE and re-evaluates hazard on the first cycle.

Verification
REQ-037 LOAD_LAT=2: ID reads rs=5, EX is a load with rt=5 -> 2 bubble cycles with pc_write=0, then pc_write=1; stall_count=2.
REQ-038 Load to rt=0 matched by rs=0 with ZERO_EXEMPT=1 -> no stall; a match with if_id_use_rt=0 on rt -> no stall.
REQ-039 LOAD_LAT=3: hazard, then mem_busy=1 for 4 cycles during LOAD_STALL -> 4 frozen cycles plus 3 bubble cycles total; stall_count=3.
REQ-040 branch_taken in the second LOAD_STALL cycle -> if_id_flush=1, next state IDLE, stall_active=0 on the following cycle.
REQ-041 stall_count at 2^CNT_W-1 with bubble=1 -> stays at maximum; perf_clr together with bubble=1 -> 0.
REQ-042 rst_n pulsed low asynchronously during LOAD_STALL -> immediate reset outputs per REQ-035; after release, IDLE with pc_write=1 when no hazard.
